// File: rtl/alu_sched.sv
// alu_sched: shares one external 8-bit add/sub ALU among NUM_REQ requesters.
// Each op walks IDLE (grant) -> EXEC (drive ALU) -> RESP (hold result until ack).
// Optional build macro ALU_SCHED_FIXED_PRIO_EN: fixed-priority arbitration
// (lowest index wins, no rotating pointer) instead of round robin.
module alu_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0] req_sel,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [7:0]           resp_data,
    output logic                 resp_carry,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_sel,
    input  logic [7:0]           alu_out,
    input  logic                 alu_carry
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [7:0]           alu_a_q, alu_a_d;
    logic [7:0]           alu_b_q, alu_b_d;
    logic [3:0]           alu_sel_q, alu_sel_d;
    logic [7:0]           resp_data_q, resp_data_d;
    logic                 resp_carry_q, resp_carry_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0]     winner;
    logic                 win_found;
    logic [IDX_W:0]       grant_inc;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    // Fixed priority: the lowest-index valid requester wins.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner    = IDX_W'(i);
                win_found = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   rr_sum;
    logic [IDX_W-1:0] rr_idx;

    // Round robin: first valid requester at or above ptr_q, wrapping to 0.
    // Scanning downward lets the smallest offset overwrite the others.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[IDX_W-1:0];
            if (req_valid[rr_idx]) begin
                winner    = rr_idx;
                win_found = 1'b1;
            end
        end
    end
`endif

    // Grant index plus one, wrapping after NUM_REQ-1; the next round-robin start.
    always_comb begin
        grant_inc = {1'b0, grant_q} + 1'b1;
        if (grant_inc == (IDX_W+1)'(NUM_REQ)) begin
            grant_inc = '0;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence and its registers.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and a latch can never be inferred.
        state_d      = state_q;
        grant_d      = grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;
        resp_valid_d = resp_valid_q;
        req_ready    = '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        ptr_d        = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[winner] = 1'b1;
                    grant_d           = winner;
                    alu_a_d           = req_a[8*winner +: 8];
                    alu_b_d           = req_b[8*winner +: 8];
                    alu_sel_d         = req_sel[4*winner +: 4];
                    state_d           = EXEC;
                end
            end
            EXEC: begin
                resp_data_d           = alu_out;
                resp_carry_d          = alu_carry;
                resp_valid_d          = '0;
                resp_valid_d[grant_q] = 1'b1;
                state_d               = RESP;
            end
            RESP: begin
                if (resp_ready[grant_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                    ptr_d        = grant_inc[IDX_W-1:0];
`endif
                end
            end
            default: begin
                resp_valid_d = '0;
                state_d      = IDLE;
            end
        endcase
    end

    // All state registers; reset abandons any in-flight op without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_valid_q <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
            resp_valid_q <= resp_valid_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;
    assign resp_valid = resp_valid_q;

endmodule
